// File: rtl/memory_game_fsm_if.sv
// Button pulses in, renderer-facing game state out.
// The master drives the buttons; the game FSM is the slave.
interface memory_game_fsm_if;
  logic       btnC;
  logic       btnU;
  logic       btnD;
  logic       btnL;
  logic       btnR;
  logic [1:0] X;
  logic [1:0] Y;
  logic [3:0] A0;
  logic [3:0] A1;
  logic [3:0] A2;
  logic [3:0] A3;
  logic [3:0] B0;
  logic [3:0] B1;
  logic [3:0] B2;
  logic [3:0] B3;
  logic       Qi;
  logic       Qfo;
  logic       Qp;
  logic       Qg;
  logic       Ql;

  modport master (
    output btnC, btnU, btnD, btnL, btnR,
    input  X, Y, A0, A1, A2, A3, B0, B1, B2, B3, Qi, Qfo, Qp, Qg, Ql
  );

  modport slave (
    input  btnC, btnU, btnD, btnL, btnR,
    output X, Y, A0, A1, A2, A3, B0, B1, B2, B3, Qi, Qfo, Qp, Qg, Ql
  );
endinterface

// File: rtl/memory_game_fsm.sv
// 4x4 memory-test game: latches a random pattern, shows it, then scores guesses.
// Tile (r,c) lives at bit 4*r+c of both the pattern and guess vectors.
module memory_game_fsm #(
  parameter int unsigned SHOW_CYCLES = 100000000,
  parameter int unsigned MAX_MISSES  = 1,
  parameter logic [15:0] SEED        = 16'hACE1
) (
  input  logic                     clk,
  input  logic                     rst,
  memory_game_fsm_if.slave         game
);

  typedef enum logic [2:0] {StIdle, StShow, StPlay, StWin, StLose} state_e;

  localparam logic [26:0] ShowLast  = 27'(SHOW_CYCLES - 1);
  localparam logic [3:0]  MissLimit = 4'(MAX_MISSES);

  state_e      r_state;
  state_e      w_state_next;
  logic [15:0] r_lfsr;
  logic [15:0] r_pat;
  logic [15:0] r_guess;
  logic [1:0]  r_x;
  logic [1:0]  r_y;
  logic [4:0]  r_hits;
  logic [4:0]  r_target;
  logic [3:0]  r_misses;
  logic [26:0] r_cnt;

  logic [3:0]  w_idx;
  logic        w_lfsr_fb;
  logic [15:0] w_mask;
  logic [15:0] w_new_pat;
  logic [4:0]  w_new_target;
  logic        w_sel_fresh;
  logic        w_sel_hit;
  logic        w_show_done;
  logic [4:0]  w_hits_inc;
  logic [3:0]  w_misses_inc;

  assign w_idx        = {r_x, r_y};
  assign w_lfsr_fb    = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];
  assign w_mask       = r_lfsr & {r_lfsr[7:0], r_lfsr[15:8]};
  // An empty board could never be won, so force a single lit tile.
  assign w_new_pat    = (w_mask == 16'h0000) ? 16'h0001 : w_mask;
  assign w_new_target = 5'($countones(w_new_pat));
  assign w_sel_fresh  = game.btnC & ~r_guess[w_idx];
  assign w_sel_hit    = r_pat[w_idx];
  assign w_show_done  = (r_cnt == ShowLast);
  assign w_hits_inc   = r_hits + 5'd1;
  assign w_misses_inc = r_misses + 4'd1;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state decision.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle: if (game.btnC) w_state_next = StShow;
      StShow: if (w_show_done) w_state_next = StPlay;
      StPlay: begin
        if (w_sel_fresh) begin
          if (w_sel_hit) begin
            if (w_hits_inc == r_target) w_state_next = StWin;
          end else if (w_misses_inc == MissLimit) begin
            w_state_next = StLose;
          end
        end
      end
      StWin, StLose: if (game.btnC) w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  // Game datapath: LFSR, pattern/guess maps, cursor, counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_lfsr   <= SEED;
      r_pat    <= '0;
      r_guess  <= '0;
      r_x      <= '0;
      r_y      <= '0;
      r_hits   <= '0;
      r_target <= '0;
      r_misses <= '0;
      r_cnt    <= '0;
    end else begin
      r_lfsr <= {r_lfsr[14:0], w_lfsr_fb};
      unique case (r_state)
        StIdle: begin
          if (game.btnC) begin
            r_pat    <= w_new_pat;
            r_target <= w_new_target;
            r_guess  <= '0;
            r_hits   <= '0;
            r_misses <= '0;
            r_x      <= '0;
            r_y      <= '0;
            r_cnt    <= '0;
          end
        end
        StShow: r_cnt <= w_show_done ? '0 : r_cnt + 27'd1;
        StPlay: begin
          // Select wins over any move pulse in the same cycle.
          if (game.btnC) begin
            if (w_sel_fresh) begin
              r_guess[w_idx] <= 1'b1;
              if (w_sel_hit) r_hits <= w_hits_inc;
              else           r_misses <= w_misses_inc;
            end
          end else if (game.btnU) begin
            r_x <= r_x - 2'd1;
          end else if (game.btnD) begin
            r_x <= r_x + 2'd1;
          end else if (game.btnL) begin
            r_y <= r_y - 2'd1;
          end else if (game.btnR) begin
            r_y <= r_y + 2'd1;
          end
        end
        StWin, StLose: begin
          if (game.btnC) begin
            r_pat   <= '0;
            r_guess <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  // Renderer outputs decoded from registered state.
  always_comb begin
    game.X   = r_x;
    game.Y   = r_y;
    game.A0  = r_pat[3:0];
    game.A1  = r_pat[7:4];
    game.A2  = r_pat[11:8];
    game.A3  = r_pat[15:12];
    game.B0  = r_guess[3:0];
    game.B1  = r_guess[7:4];
    game.B2  = r_guess[11:8];
    game.B3  = r_guess[15:12];
    game.Qi  = 1'b0;
    game.Qfo = 1'b0;
    game.Qp  = 1'b0;
    game.Qg  = 1'b0;
    game.Ql  = 1'b0;
    unique case (r_state)
      StIdle:  game.Qi  = 1'b1;
      StShow:  game.Qfo = 1'b1;
      StPlay:  game.Qp  = 1'b1;
      StWin:   game.Qg  = 1'b1;
      StLose:  game.Ql  = 1'b1;
      default: game.Qi  = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_memory_game_fsm.sv
// Bench for memory_game_fsm: two DUTs (MAX_MISSES 1 and 2) share one stimulus stream
// and are compared every cycle against a tile-level model of the game rules.
module tb_memory_game_fsm;
  localparam int unsigned Show = 4;
  localparam logic [15:0] Seed = 16'hACE1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic bc = 1'b0, bu = 1'b0, bd = 1'b0, bl = 1'b0, br = 1'b0;

  memory_game_fsm_if g0 ();
  memory_game_fsm_if g1 ();

  assign g0.btnC = bc;
  assign g0.btnU = bu;
  assign g0.btnD = bd;
  assign g0.btnL = bl;
  assign g0.btnR = br;
  assign g1.btnC = bc;
  assign g1.btnU = bu;
  assign g1.btnD = bd;
  assign g1.btnL = bl;
  assign g1.btnR = br;

  memory_game_fsm #(.SHOW_CYCLES(Show), .MAX_MISSES(1), .SEED(Seed)) dut0 (
    .clk (clk),
    .rst (rst),
    .game(g0)
  );

  memory_game_fsm #(.SHOW_CYCLES(Show), .MAX_MISSES(2), .SEED(Seed)) dut1 (
    .clk (clk),
    .rst (rst),
    .game(g1)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int d, input logic [15:0] act,
                     input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d got %h want %h at %0t", name, d, act, exp, $time);
    end
  endtask

  // Observed outputs, packed per DUT.
  logic [3:0]  o_xy [2];
  logic [15:0] o_a  [2];
  logic [15:0] o_b  [2];
  logic [4:0]  o_q  [2];
  assign o_xy[0] = {g0.X, g0.Y};
  assign o_xy[1] = {g1.X, g1.Y};
  assign o_a[0]  = {g0.A3, g0.A2, g0.A1, g0.A0};
  assign o_a[1]  = {g1.A3, g1.A2, g1.A1, g1.A0};
  assign o_b[0]  = {g0.B3, g0.B2, g0.B1, g0.B0};
  assign o_b[1]  = {g1.B3, g1.B2, g1.B1, g1.B0};
  assign o_q[0]  = {g0.Qi, g0.Qfo, g0.Qp, g0.Qg, g0.Ql};
  assign o_q[1]  = {g1.Qi, g1.Qfo, g1.Qp, g1.Qg, g1.Ql};

  // Model: phase 0 idle, 1 show, 2 play, 3 win, 4 lose.
  int          ph [2];
  bit          pat [2][16];
  bit          gs  [2][16];
  int          mx [2], my [2], hits [2], misses [2], cnt [2], target [2];
  logic [15:0] lf [2];
  bit          mvalid = 1'b0;

  task automatic mstep(input int d);
    logic [15:0] old;
    logic [15:0] p;
    int          i;
    int          lim;
    lim = (d == 0) ? 1 : 2;
    if (rst) begin
      ph[d] = 0;
      for (int k = 0; k < 16; k++) begin
        pat[d][k] = 1'b0;
        gs[d][k]  = 1'b0;
      end
      mx[d] = 0; my[d] = 0; hits[d] = 0; misses[d] = 0; cnt[d] = 0;
      lf[d] = Seed;
      return;
    end
    old   = lf[d];
    lf[d] = {old[14:0], old[15] ^ old[13] ^ old[12] ^ old[10]};
    case (ph[d])
      0: if (bc) begin
        p = old & {old[7:0], old[15:8]};
        if (p == 16'h0000) p = 16'h0001;
        target[d] = 0;
        for (int k = 0; k < 16; k++) begin
          pat[d][k] = p[k];
          gs[d][k]  = 1'b0;
          target[d] += int'(p[k]);
        end
        hits[d] = 0; misses[d] = 0; mx[d] = 0; my[d] = 0; cnt[d] = 0;
        ph[d] = 1;
      end
      1: if (cnt[d] == Show - 1) begin
        ph[d] = 2; cnt[d] = 0;
      end else begin
        cnt[d]++;
      end
      2: if (bc) begin
        i = mx[d] * 4 + my[d];
        if (!gs[d][i]) begin
          gs[d][i] = 1'b1;
          if (pat[d][i]) begin
            hits[d]++;
            if (hits[d] == target[d]) ph[d] = 3;
          end else begin
            misses[d]++;
            if (misses[d] == lim) ph[d] = 4;
          end
        end
      end else if (bu) mx[d] = (mx[d] + 3) % 4;
      else if (bd) mx[d] = (mx[d] + 1) % 4;
      else if (bl) my[d] = (my[d] + 3) % 4;
      else if (br) my[d] = (my[d] + 1) % 4;
      default: if (bc) begin
        for (int k = 0; k < 16; k++) begin
          pat[d][k] = 1'b0;
          gs[d][k]  = 1'b0;
        end
        ph[d] = 0;
      end
    endcase
  endtask

  initial forever begin
    @(posedge clk);
    mstep(0);
    mstep(1);
    if (rst) mvalid = 1'b1;
  end

  // Per-cycle comparison of every output against the model.
  initial forever begin
    @(negedge clk);
    if (mvalid) begin
      for (int d = 0; d < 2; d++) begin
        logic [15:0] ea, eb;
        for (int k = 0; k < 16; k++) begin
          ea[k] = pat[d][k];
          eb[k] = gs[d][k];
        end
        chk("cursor", d, 16'(o_xy[d]), 16'({2'(mx[d]), 2'(my[d])}));
        chk("pattern", d, o_a[d], ea);
        chk("guess", d, o_b[d], eb);
        chk("phase", d, 16'(o_q[d]), 16'(5'b10000 >> ph[d]));
      end
    end
  end

  task automatic drive(input bit c, input bit u, input bit dn, input bit l, input bit r,
                       input bit rs);
    bc = c; bu = u; bd = dn; bl = l; br = r; rst = rs;
    @(posedge clk);
    #2;
    bc = 0; bu = 0; bd = 0; bl = 0; br = 0; rst = 0;
  endtask

  int n;

  initial begin
    drive(0, 0, 0, 0, 0, 1);
    chk("reset_q", 0, 16'(o_q[0]), 16'h10);
    chk("reset_a", 0, o_a[0], 16'h0000);

    // Pattern from SEED: ACE1 & E1AC = A0A0.
    drive(1, 0, 0, 0, 0, 0);
    chk("pat_A0", 0, 16'(g0.A0), 16'h0);
    chk("pat_A1", 0, 16'(g0.A1), 16'hA);
    chk("pat_A2", 0, 16'(g0.A2), 16'h0);
    chk("pat_A3", 0, 16'(g0.A3), 16'hA);
    chk("show_q", 0, 16'(g0.Qfo), 16'h1);
    n = 1;
    for (int t = 0; t < 20 && g0.Qfo; t++) begin
      drive(0, 0, 0, 0, 0, 0);
      if (g0.Qfo) n++;
    end
    chk("show_len", 0, 16'(n), 16'd4);
    chk("play_q", 0, 16'(g0.Qp), 16'h1);

    // Cursor wrap both ways.
    drive(0, 1, 0, 0, 0, 0);
    drive(0, 0, 0, 1, 0, 0);
    chk("wrap_ul", 0, 16'(o_xy[0]), 16'hF);
    drive(0, 0, 1, 0, 0, 0);
    drive(0, 0, 0, 0, 1, 0);
    chk("wrap_dr", 0, 16'(o_xy[0]), 16'h0);

    // Select with simultaneous move at (1,1).
    drive(0, 0, 1, 0, 0, 0);
    drive(0, 0, 0, 0, 1, 0);
    drive(1, 0, 0, 0, 1, 0);
    chk("sel_B1", 0, 16'(g0.B1), 16'h2);
    chk("sel_y", 0, 16'(g0.Y), 16'h1);
    drive(0, 1, 0, 0, 1, 0);
    chk("up_right", 0, 16'(o_xy[0]), 16'h1);
    drive(0, 0, 1, 0, 0, 0);

    // Repeat select then miss at (0,0).
    drive(1, 0, 0, 0, 0, 0);
    chk("repeat_B", 0, o_b[0], 16'h0020);
    chk("repeat_q", 0, 16'(g0.Qp), 16'h1);
    drive(0, 0, 0, 1, 0, 0);
    drive(0, 1, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0);
    chk("miss_B0", 0, 16'(g0.B0), 16'h1);
    chk("lose_q", 0, 16'(g0.Ql), 16'h1);
    chk("miss2_q", 1, 16'(g1.Qp), 16'h1);

    // Finish the win on the MAX_MISSES=2 instance: (1,3), (3,3), (3,1).
    drive(0, 0, 1, 0, 0, 0);
    drive(0, 0, 0, 1, 0, 0);
    drive(1, 0, 0, 0, 0, 0);
    drive(0, 0, 1, 0, 0, 0);
    drive(0, 0, 1, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 1, 0, 0);
    drive(0, 0, 0, 1, 0, 0);
    drive(1, 0, 0, 0, 0, 0);
    chk("win_B1", 1, 16'(g1.B1), 16'hA);
    chk("win_B3", 1, 16'(g1.B3), 16'hA);
    chk("win_q", 1, 16'(g1.Qg), 16'h1);
    drive(1, 0, 0, 0, 0, 0);
    chk("restart_q", 1, 16'(g1.Qi), 16'h1);
    chk("restart_a", 1, o_a[1], 16'h0);
    chk("restart_b", 1, o_b[1], 16'h0);

    // Reset during show, then during play; pattern must repeat from SEED.
    drive(1, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 1);
    chk("rst_show_q", 1, 16'(g1.Qi), 16'h1);
    chk("rst_show_xy", 0, 16'(o_xy[0]), 16'h0);
    drive(1, 0, 0, 0, 0, 0);
    chk("reseed_a", 1, o_a[1], 16'hA0A0);
    chk("reseed_a", 0, o_a[0], 16'hA0A0);
    for (int t = 0; t < 4; t++) drive(0, 0, 0, 0, 0, 0);
    chk("reseed_play", 1, 16'(g1.Qp), 16'h1);
    drive(0, 0, 1, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 1);
    chk("rst_play_q", 1, 16'(g1.Qi), 16'h1);
    chk("rst_play_x", 1, 16'(g1.X), 16'h0);

    // Random play, rare resets.
    for (int t = 0; t < 4000; t++) begin
      drive($urandom_range(0, 5) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
            $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
            $urandom_range(0, 499) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
